cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multi-cycle control sequencer for the 16-bit processor datapath. It fetches each instruction over the shared system bus, decodes the 5-bit `Opcode_t`, and drives the datapath select fields (`pc_select_t`, `Op1_select_t`, `Op2_select_t`, `Imm_select_t`, `Wd_select_t`, `Rs1_select_t`, `Lr_select_t`), the ALU function (`alu_functions_t`) and all write strobes. It sits between the instruction register/flags outputs of the datapath and the memory handshake, using the types in `opcodes`.

## Interface
- No parameters; all field widths come from the `opcodes` package.
- Clock  in  1  system clock, all state on rising edge
- nReset  in  1  synchronous, active-low reset
- Instr  in  16  current instruction register contents; opcode = [15:11], branch condition = [10:8] (`Branch_t`), stack op = [10:9] (`Stack_t`)
- Flags  in  4  Z/C/V/N at `FLAGS_Z`/`FLAGS_C`/`FLAGS_V`/`FLAGS_N`
- MemAck  in  1  memory completes the current request this cycle
- MemReq, MemWrite  out  1  bus request and write qualifier
- AddrSel  out  2  bus address: 0 = PC, 1 = ALU out, 2 = SP
- IrWe, PcWe, RegWe, LrWe, FlagsWe  out  1  write strobes
- SpOp  out  2  0 hold, 1 increment, 2 decrement
- PcSel, Op1Sel  out  2  `pc_select_t`, `Op1_select_t`
- Op2Sel, ImmSel, WdSel, Rs1Sel, LrSel  out  1  enum selects
- AluFn  out  4  `alu_functions_t`
- Illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- State register only: FETCH, EXEC, MEM. All outputs are combinational from State, Instr, Flags and MemAck.
- FETCH
  - Drives MemReq=1, MemWrite=0, AddrSel=PC.
  - Holds until MemAck. On ack: IrWe=1, PcWe=1, PcSel=Pc1, next state EXEC.
- EXEC, ALU group:
  - ADD/ADC/SUB/SUC/AND/OR/NOT/LSL/LSR map to FnADD/FnADC/FnSUB/FnSUC/FnAND/FnOR/FnNOT/FnLSL/FnLSR.
  - Operands: Op1Sel=Op1Rd1, Op2Sel=Op2Rd2. Strobes: RegWe=1, FlagsWe=1, WdSel=WdAlu. Next state FETCH.
  - Immediate forms ADDI/ADCI/SUBI/SUCI use Op2Imm with ImmShort. ADDIB/SUBIB use Op2Imm with ImmLong.
  - CMP: FnSUB with FlagsWe=1 and RegWe=0.
  - LUI/LLI: FnIMM, ImmLong, RegWe=1, FlagsWe=0.
  - NOP: no strobes.
- EXEC, unsupported opcodes: NEG/XOR/NAND/NOR/ASR have no ALU function code, and any undefined opcode is treated the same way. Response: Illegal=1, no strobes, next state FETCH.
- EXEC, LDW/STW
  - FnADD, Op1Rd1, Op2Imm, ImmShort; next state MEM.
  - STW also sets Rs1Sel=Rs1Rd so the store data reads Rd.
- EXEC, BRANCH: condition from Instr[10:8].
  - BR: always taken.
  - BNE: taken if !Z. BE: taken if Z.
  - BLT: taken if N^V. BGE: taken if !(N^V).
  - Taken branch: PcWe=1, PcSel=PcAluOut, Op1Pc, Op2Imm, ImmLong, FnADD.
  - BWL: always taken, and also LrWe=1, LrSel=LrPc.
  - RET: PcWe=1, PcSel=PcLr.
  - JMP: PcSel=PcAluOut, Op1Rd1, Op2Imm, ImmShort.
  - All branches: next state FETCH. Not-taken branches drive no strobes.
- EXEC, PUSH_POP: Stack_t taken from Instr[10:9].
  - PUSH/PUSH_LINK: SpOp=decrement (pre-decrement), next state MEM.
  - POP/POP_LINK: next state MEM with SpOp=hold.
- MEM: MemReq=1, held until MemAck. Select fields stay stable for the whole MEM state.
  - LDW: AddrSel=ALU. On ack: RegWe=1, WdSel=WdSys.
  - STW: AddrSel=ALU, MemWrite=1.
  - PUSH: AddrSel=SP, MemWrite=1, data taken from Rd.
  - PUSH_LINK: as PUSH, with data taken from LR.
  - POP: AddrSel=SP. On ack: RegWe=1, WdSel=WdSys, SpOp=increment.
  - POP_LINK: as POP, but on ack LrWe=1 and LrSel=LrSys instead of RegWe.
  - All cases: next state FETCH after ack.

## Timing
- Reset:
  - While nReset=0, every output is forced to 0, which gives AluFn=FnNOP and SpOp=hold.
  - The first rising edge with nReset=0 sets State=FETCH.
  - Reset asserted mid-MEM abandons the access: MemReq drops in that same cycle and no strobe fires.
- MemAck is sampled in the cycle MemReq is high. Zero-wait memory acks in the same cycle, so FETCH takes 1 cycle.
- Latency with zero-wait memory:
  - ALU ops, branches, NOP and illegal opcodes: 2 cycles.
  - LDW/STW/PUSH/POP: 3 cycles.
  - Each wait cycle adds 1 cycle to FETCH or MEM.
- Strobes are asserted for exactly one cycle per instruction. MemAck is ignored in EXEC.
- A PC write in FETCH and a PC write in EXEC never occur in the same cycle.

## Test plan
- Reset: nReset=0 for 2 cycles, with MemAck=1 -> all outputs 0. First cycle after release -> MemReq=1, AddrSel=0.
- ADD R1,R2,R3 with zero-wait memory -> cycle 1 IrWe=PcWe=1, PcSel=Pc1. Cycle 2: RegWe=FlagsWe=1, AluFn=FnADD. Next cycle is a fetch.
- BNE: with Z=1 -> PcWe=0 in EXEC. With Z=0 -> PcWe=1, PcSel=PcAluOut. BWL -> additionally LrWe=1, LrSel=LrPc.
- LDW with MemAck delayed 3 cycles in MEM -> MemReq held 4 cycles with AddrSel=1. RegWe=1 and WdSel=WdSys only in the ack cycle.
- PUSH_LINK then POP_LINK:
  - PUSH_LINK: SpOp=2 in EXEC; MemWrite=1 with AddrSel=2 in MEM.
  - POP_LINK: LrWe=1, LrSel=LrSys and SpOp=1 on the ack.
- Opcode XOR (5'b10010) -> Illegal=1 for one cycle, no strobes, fetch resumes. nReset pulsed during MEM of STW -> MemReq=0 that cycle, then FETCH.

Source files
------------

// File: rtl/opcodes.sv
`default_nettype none
// ============================================================================
//  Package  : opcodes
//  Purpose  : Shared instruction and datapath-select encodings for the
//             16-bit processor (opcode, branch/stack sub-ops, ALU functions,
//             datapath mux selects and flag bit positions).
//  Revision : 1.0  initial release
// ============================================================================
package opcodes;

  // Primary opcode, Instr[15:11]
  typedef enum logic [4:0] {
    NOP      = 5'd0,
    ADD      = 5'd1,
    ADC      = 5'd2,
    SUB      = 5'd3,
    SUC      = 5'd4,
    AND      = 5'd5,
    OR       = 5'd6,
    NOT      = 5'd7,
    LSL      = 5'd8,
    LSR      = 5'd9,
    ADDI     = 5'd10,
    ADCI     = 5'd11,
    SUBI     = 5'd12,
    SUCI     = 5'd13,
    ADDIB    = 5'd14,
    SUBIB    = 5'd15,
    CMP      = 5'd16,
    NEG      = 5'd17,
    XOR      = 5'd18,
    NAND     = 5'd19,
    NOR      = 5'd20,
    ASR      = 5'd21,
    LUI      = 5'd22,
    LLI      = 5'd23,
    LDW      = 5'd24,
    STW      = 5'd25,
    BRANCH   = 5'd26,
    PUSH_POP = 5'd27
  } Opcode_t;

  // Branch condition, Instr[10:8]
  typedef enum logic [2:0] {
    BR  = 3'd0,
    BNE = 3'd1,
    BE  = 3'd2,
    BLT = 3'd3,
    BGE = 3'd4,
    BWL = 3'd5,
    RET = 3'd6,
    JMP = 3'd7
  } Branch_t;

  // Stack operation, Instr[10:9]
  typedef enum logic [1:0] {
    PUSH      = 2'd0,
    POP       = 2'd1,
    PUSH_LINK = 2'd2,
    POP_LINK  = 2'd3
  } Stack_t;

  // ALU function; zero is the idle code so a cleared bus means "no operation"
  typedef enum logic [3:0] {
    FnNOP = 4'd0,
    FnADD = 4'd1,
    FnADC = 4'd2,
    FnSUB = 4'd3,
    FnSUC = 4'd4,
    FnAND = 4'd5,
    FnOR  = 4'd6,
    FnNOT = 4'd7,
    FnLSL = 4'd8,
    FnLSR = 4'd9,
    FnIMM = 4'd10
  } alu_functions_t;

  typedef enum logic [1:0] {Pc1 = 2'd0, PcAluOut = 2'd1, PcLr = 2'd2} pc_select_t;
  typedef enum logic [1:0] {Op1Rd1 = 2'd0, Op1Pc = 2'd1, Op1Zero = 2'd2} Op1_select_t;
  typedef enum logic {Op2Rd2 = 1'b0, Op2Imm = 1'b1} Op2_select_t;
  typedef enum logic {ImmShort = 1'b0, ImmLong = 1'b1} Imm_select_t;
  typedef enum logic {WdAlu = 1'b0, WdSys = 1'b1} Wd_select_t;
  typedef enum logic {Rs1Ra = 1'b0, Rs1Rd = 1'b1} Rs1_select_t;
  typedef enum logic {LrPc = 1'b0, LrSys = 1'b1} Lr_select_t;

  // Bit positions inside the 4-bit flags vector
  localparam int unsigned FLAGS_Z = 0;
  localparam int unsigned FLAGS_C = 1;
  localparam int unsigned FLAGS_V = 2;
  localparam int unsigned FLAGS_N = 3;

endpackage
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_fsm
//  Purpose  : Multi-cycle FETCH/EXEC/MEM control sequencer for the 16-bit
//             datapath. Only the state is registered; every control output is
//             decoded combinationally from state, Instr, Flags and MemAck so a
//             zero-wait memory completes a fetch in a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_control_fsm
  import opcodes::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] Instr,
  input  logic [3:0]  Flags,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [1:0]  AddrSel,
  output logic        IrWe,
  output logic        PcWe,
  output logic        RegWe,
  output logic        LrWe,
  output logic        FlagsWe,
  output logic [1:0]  SpOp,
  output logic [1:0]  PcSel,
  output logic [1:0]  Op1Sel,
  output logic        Op2Sel,
  output logic        ImmSel,
  output logic        WdSel,
  output logic        Rs1Sel,
  output logic        LrSel,
  output logic [3:0]  AluFn,
  output logic        Illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  // Bus address and stack-pointer encodings
  localparam logic [1:0] c_ADDR_PC  = 2'd0;
  localparam logic [1:0] c_ADDR_ALU = 2'd1;
  localparam logic [1:0] c_ADDR_SP  = 2'd2;
  localparam logic [1:0] c_SP_HOLD  = 2'd0;
  localparam logic [1:0] c_SP_INC   = 2'd1;
  localparam logic [1:0] c_SP_DEC   = 2'd2;

  state_t  r_state;
  state_t  w_next;
  Opcode_t w_op;
  Branch_t w_cond;
  Stack_t  w_stk;
  logic    w_taken;
  logic    w_is_push;
  logic    w_unused;

  // The IR only changes on a fetch ack, so these decodes stay stable
  // through EXEC and MEM of the same instruction.
  assign w_op      = Opcode_t'(Instr[15:11]);
  assign w_cond    = Branch_t'(Instr[10:8]);
  assign w_stk     = Stack_t'(Instr[10:9]);
  assign w_is_push = (w_stk == PUSH) || (w_stk == PUSH_LINK);
  assign w_unused  = ^{Flags[FLAGS_C], Instr[7:0]};

  // Branch condition evaluation from the Z/V/N flags
  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      BR, BWL, RET, JMP: w_taken = 1'b1;
      BNE:               w_taken = ~Flags[FLAGS_Z];
      BE:                w_taken = Flags[FLAGS_Z];
      BLT:               w_taken = Flags[FLAGS_N] ^ Flags[FLAGS_V];
      BGE:               w_taken = ~(Flags[FLAGS_N] ^ Flags[FLAGS_V]);
      default:           w_taken = 1'b0;
    endcase
  end

  // State register; reset always returns to FETCH
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Output and next-state decode; everything stays zero while in reset,
  // which also abandons any in-flight memory access immediately.
  always_comb begin
    w_next   = S_FETCH;
    MemReq   = 1'b0;
    MemWrite = 1'b0;
    AddrSel  = c_ADDR_PC;
    IrWe     = 1'b0;
    PcWe     = 1'b0;
    RegWe    = 1'b0;
    LrWe     = 1'b0;
    FlagsWe  = 1'b0;
    SpOp     = c_SP_HOLD;
    PcSel    = Pc1;
    Op1Sel   = Op1Rd1;
    Op2Sel   = Op2Rd2;
    ImmSel   = ImmShort;
    WdSel    = WdAlu;
    Rs1Sel   = Rs1Ra;
    LrSel    = LrPc;
    AluFn    = FnNOP;
    Illegal  = 1'b0;

    if (nReset) begin
      case (r_state)
        S_FETCH: begin
          MemReq  = 1'b1;
          AddrSel = c_ADDR_PC;
          if (MemAck) begin
            IrWe   = 1'b1;
            PcWe   = 1'b1;
            PcSel  = Pc1;
            w_next = S_EXEC;
          end else begin
            w_next = S_FETCH;
          end
        end

        S_EXEC: begin
          w_next = S_FETCH;
          case (w_op)
            ADD, ADC, SUB, SUC, AND, OR, NOT, LSL, LSR: begin
              RegWe   = 1'b1;
              FlagsWe = 1'b1;
              case (w_op)
                ADD:     AluFn = FnADD;
                ADC:     AluFn = FnADC;
                SUB:     AluFn = FnSUB;
                SUC:     AluFn = FnSUC;
                AND:     AluFn = FnAND;
                OR:      AluFn = FnOR;
                NOT:     AluFn = FnNOT;
                LSL:     AluFn = FnLSL;
                default: AluFn = FnLSR;
              endcase
            end
            ADDI, ADCI, SUBI, SUCI: begin
              RegWe   = 1'b1;
              FlagsWe = 1'b1;
              Op2Sel  = Op2Imm;
              ImmSel  = ImmShort;
              case (w_op)
                ADDI:    AluFn = FnADD;
                ADCI:    AluFn = FnADC;
                SUBI:    AluFn = FnSUB;
                default: AluFn = FnSUC;
              endcase
            end
            ADDIB, SUBIB: begin
              RegWe   = 1'b1;
              FlagsWe = 1'b1;
              Op2Sel  = Op2Imm;
              ImmSel  = ImmLong;
              AluFn   = (w_op == ADDIB) ? FnADD : FnSUB;
            end
            CMP: begin
              FlagsWe = 1'b1;
              AluFn   = FnSUB;
            end
            LUI, LLI: begin
              RegWe  = 1'b1;
              Op2Sel = Op2Imm;
              ImmSel = ImmLong;
              AluFn  = FnIMM;
            end
            NOP: begin
            end
            LDW, STW: begin
              // Address computation Rd1 + short immediate, used in MEM
              AluFn  = FnADD;
              Op2Sel = Op2Imm;
              ImmSel = ImmShort;
              Rs1Sel = (w_op == STW) ? Rs1Rd : Rs1Ra;
              w_next = S_MEM;
            end
            BRANCH: begin
              case (w_cond)
                RET: begin
                  PcWe  = 1'b1;
                  PcSel = PcLr;
                end
                JMP: begin
                  PcWe   = 1'b1;
                  PcSel  = PcAluOut;
                  Op2Sel = Op2Imm;
                  ImmSel = ImmShort;
                  AluFn  = FnADD;
                end
                default: begin
                  // PC-relative target; selects are driven even when not taken
                  PcWe   = w_taken;
                  PcSel  = PcAluOut;
                  Op1Sel = Op1Pc;
                  Op2Sel = Op2Imm;
                  ImmSel = ImmLong;
                  AluFn  = FnADD;
                  if (w_cond == BWL) begin
                    LrWe  = 1'b1;
                    LrSel = LrPc;
                  end
                end
              endcase
            end
            PUSH_POP: begin
              SpOp   = w_is_push ? c_SP_DEC : c_SP_HOLD;
              w_next = S_MEM;
            end
            default: begin
              // NEG/XOR/NAND/NOR/ASR and undefined codes
              Illegal = 1'b1;
            end
          endcase
        end

        S_MEM: begin
          w_next = MemAck ? S_FETCH : S_MEM;
          MemReq = 1'b1;
          case (w_op)
            LDW, STW: begin
              AddrSel  = c_ADDR_ALU;
              AluFn    = FnADD;
              Op2Sel   = Op2Imm;
              ImmSel   = ImmShort;
              MemWrite = (w_op == STW);
              Rs1Sel   = (w_op == STW) ? Rs1Rd : Rs1Ra;
              WdSel    = (w_op == LDW) ? WdSys : WdAlu;
              RegWe    = (w_op == LDW) && MemAck;
            end
            PUSH_POP: begin
              AddrSel = c_ADDR_SP;
              case (w_stk)
                PUSH: begin
                  MemWrite = 1'b1;
                  Rs1Sel   = Rs1Rd;
                end
                PUSH_LINK: begin
                  MemWrite = 1'b1;
                end
                POP: begin
                  WdSel = WdSys;
                  RegWe = MemAck;
                  SpOp  = MemAck ? c_SP_INC : c_SP_HOLD;
                end
                default: begin
                  LrSel = LrSys;
                  LrWe  = MemAck;
                  SpOp  = MemAck ? c_SP_INC : c_SP_HOLD;
                end
              endcase
            end
            default: begin
              // Unreachable for a stable IR; drop the request and refetch
              MemReq = 1'b0;
              w_next = S_FETCH;
            end
          endcase
        end

        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control_fsm
//  Purpose  : Self-checking bench: directed scenarios with literal expected
//             values plus randomized instructions, memory waits, flags and
//             reset pulses, all compared each cycle against a behavioural
//             model of the instruction phases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_control_fsm;
  import opcodes::*;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] Instr;
  logic [3:0]  Flags;
  logic        MemAck;
  logic        MemReq, MemWrite, IrWe, PcWe, RegWe, LrWe, FlagsWe;
  logic [1:0]  AddrSel, SpOp, PcSel, Op1Sel;
  logic        Op2Sel, ImmSel, WdSel, Rs1Sel, LrSel, Illegal;
  logic [3:0]  AluFn;

  typedef struct packed {
    logic       mreq;
    logic       mwr;
    logic [1:0] addr;
    logic       irwe;
    logic       pcwe;
    logic       rwe;
    logic       lrwe;
    logic       fwe;
    logic [1:0] sp;
    logic [1:0] pcs;
    logic [1:0] op1;
    logic       op2;
    logic       imm;
    logic       wd;
    logic       rs1;
    logic       lrs;
    logic [3:0] fn;
    logic       ill;
  } outs_t;

  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_MEM   = 2;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          m_phase = PH_FETCH;
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] next_instr = 16'h0000;
  bit          chk_en = 1'b0;
  outs_t       dut_o;

  assign dut_o = {MemReq, MemWrite, AddrSel, IrWe, PcWe, RegWe, LrWe, FlagsWe,
                  SpOp, PcSel, Op1Sel, Op2Sel, ImmSel, WdSel, Rs1Sel, LrSel,
                  AluFn, Illegal};

  cpu_control_fsm dut (
    .Clock(Clock), .nReset(nReset), .Instr(Instr), .Flags(Flags), .MemAck(MemAck),
    .MemReq(MemReq), .MemWrite(MemWrite), .AddrSel(AddrSel),
    .IrWe(IrWe), .PcWe(PcWe), .RegWe(RegWe), .LrWe(LrWe), .FlagsWe(FlagsWe),
    .SpOp(SpOp), .PcSel(PcSel), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel),
    .ImmSel(ImmSel), .WdSel(WdSel), .Rs1Sel(Rs1Sel), .LrSel(LrSel),
    .AluFn(AluFn), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] sub,
                                     input logic [7:0] lo);
    return {op, sub, lo};
  endfunction

  // ALU function implied by an arithmetic/logic opcode name
  function automatic logic [3:0] arith_fn(input logic [4:0] op);
    case (op)
      ADD, ADDI, ADDIB:  return FnADD;
      ADC, ADCI:         return FnADC;
      SUB, SUBI, SUBIB:  return FnSUB;
      SUC, SUCI:         return FnSUC;
      AND:               return FnAND;
      OR:                return FnOR;
      NOT:               return FnNOT;
      LSL:               return FnLSL;
      LSR:               return FnLSR;
      default:           return FnNOP;
    endcase
  endfunction

  function automatic bit uses_mem(input logic [4:0] op);
    return (op == LDW) || (op == STW) || (op == PUSH_POP);
  endfunction

  // Expected control outputs for one cycle of an instruction
  function automatic outs_t model(input int ph, input logic [15:0] ins,
                                  input logic [3:0] fl, input logic ack,
                                  input logic rn);
    outs_t      o;
    logic [4:0] op;
    logic [2:0] bc;
    logic [1:0] so;
    bit         take;
    o  = '0;
    op = ins[15:11];
    bc = ins[10:8];
    so = ins[10:9];
    if (!rn) return o;
    if (ph == PH_FETCH) begin
      o.mreq = 1'b1;
      o.irwe = ack;
      o.pcwe = ack;
      return o;
    end
    if (ph == PH_EXEC) begin
      if (op inside {ADD, ADC, SUB, SUC, AND, OR, NOT, LSL, LSR}) begin
        o.fn = arith_fn(op); o.rwe = 1; o.fwe = 1;
      end else if (op inside {ADDI, ADCI, SUBI, SUCI}) begin
        o.fn = arith_fn(op); o.rwe = 1; o.fwe = 1; o.op2 = 1;
      end else if (op inside {ADDIB, SUBIB}) begin
        o.fn = arith_fn(op); o.rwe = 1; o.fwe = 1; o.op2 = 1; o.imm = 1;
      end else if (op == CMP) begin
        o.fn = FnSUB; o.fwe = 1;
      end else if (op inside {LUI, LLI}) begin
        o.fn = FnIMM; o.rwe = 1; o.op2 = 1; o.imm = 1;
      end else if (op == NOP) begin
        o = '0;
      end else if (op inside {LDW, STW}) begin
        o.fn = FnADD; o.op2 = 1; o.rs1 = (op == STW);
      end else if (op == BRANCH) begin
        if (bc == RET) begin
          o.pcwe = 1; o.pcs = PcLr;
        end else if (bc == JMP) begin
          o.pcwe = 1; o.pcs = PcAluOut; o.op2 = 1; o.fn = FnADD;
        end else begin
          case (bc)
            BNE:     take = !fl[FLAGS_Z];
            BE:      take = fl[FLAGS_Z];
            BLT:     take = fl[FLAGS_N] != fl[FLAGS_V];
            BGE:     take = fl[FLAGS_N] == fl[FLAGS_V];
            default: take = 1;
          endcase
          o.pcwe = take; o.pcs = PcAluOut; o.op1 = Op1Pc; o.op2 = 1; o.imm = 1;
          o.fn = FnADD;
          if (bc == BWL) begin o.lrwe = 1; o.lrs = LrPc; end
        end
      end else if (op == PUSH_POP) begin
        o.sp = (so == PUSH || so == PUSH_LINK) ? 2'd2 : 2'd0;
      end else begin
        o.ill = 1;
      end
      return o;
    end
    // memory phase
    o.mreq = 1'b1;
    if (op == LDW) begin
      o.addr = 1; o.fn = FnADD; o.op2 = 1; o.wd = 1; o.rwe = ack;
    end else if (op == STW) begin
      o.addr = 1; o.fn = FnADD; o.op2 = 1; o.mwr = 1; o.rs1 = 1;
    end else if (so == PUSH) begin
      o.addr = 2; o.mwr = 1; o.rs1 = 1;
    end else if (so == PUSH_LINK) begin
      o.addr = 2; o.mwr = 1;
    end else if (so == POP) begin
      o.addr = 2; o.wd = 1; o.rwe = ack; o.sp = ack ? 2'd1 : 2'd0;
    end else begin
      o.addr = 2; o.lrs = 1; o.lrwe = ack; o.sp = ack ? 2'd1 : 2'd0;
    end
    return o;
  endfunction

  // Model phase tracking and the datapath's instruction register
  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (!nReset) begin
      m_phase <= PH_FETCH;
    end else if (m_phase == PH_FETCH) begin
      if (MemAck) begin
        m_phase <= PH_EXEC;
        m_ir    <= next_instr;
      end
    end else if (m_phase == PH_EXEC) begin
      m_phase <= uses_mem(m_ir[15:11]) ? PH_MEM : PH_FETCH;
    end else if (MemAck) begin
      m_phase <= PH_FETCH;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge Clock) begin
    outs_t e;
    if (chk_en) begin
      e = model(m_phase, Instr, Flags, MemAck, nReset);
      total++;
      if (dut_o !== e) begin
        bad++;
        $display("FAIL model cyc=%0d phase=%0d instr=%h got=%h want=%h",
                 cyc, m_phase, Instr, dut_o, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic step(input logic rn, input logic ack, input logic [3:0] fl);
    @(posedge Clock);
    #1;
    nReset = rn;
    MemAck = ack;
    Flags  = fl;
    Instr  = m_ir;
    @(negedge Clock);
  endtask

  task automatic fetch(input logic [15:0] ins);
    next_instr = ins;
    step(1'b1, 1'b1, 4'h0);
  endtask

  initial begin
    nReset = 1'b0;
    MemAck = 1'b1;
    Flags  = 4'h0;
    Instr  = 16'h0000;
    chk_en = 1'b1;

    // Reset with MemAck high: everything quiet
    step(1'b0, 1'b1, 4'h0); chk("rst_c0", 32'(dut_o), 32'd0);
    step(1'b0, 1'b1, 4'h0); chk("rst_c1", 32'(dut_o), 32'd0);
    step(1'b1, 1'b0, 4'h0);
    chk("post_rst_req", 32'(MemReq), 32'd1);
    chk("post_rst_addr", 32'(AddrSel), 32'd0);
    chk("post_rst_irwe", 32'(IrWe), 32'd0);

    // ADD R1,R2,R3
    fetch(mk(ADD, 3'd1, 8'h23));
    chk("add_fetch", 32'({IrWe, PcWe, PcSel}), 32'b1100);
    step(1'b1, 1'b0, 4'h0);
    chk("add_exec", 32'({RegWe, FlagsWe, AluFn, PcWe}), 32'b11_0001_0);

    // BNE taken/not taken, then BWL
    fetch(mk(BRANCH, BNE, 8'h10));
    chk("add_next_fetch", 32'({MemReq, RegWe}), 32'b10);
    step(1'b1, 1'b0, 4'b0001); chk("bne_z1", 32'(PcWe), 32'd0);
    fetch(mk(BRANCH, BNE, 8'h10));
    step(1'b1, 1'b0, 4'b0000); chk("bne_z0", 32'({PcWe, PcSel}), 32'b101);
    fetch(mk(BRANCH, BWL, 8'h40));
    step(1'b1, 1'b0, 4'b0001);
    chk("bwl", 32'({PcWe, LrWe, LrSel}), 32'b110);

    // LDW with three wait cycles in MEM
    fetch(mk(LDW, 3'd2, 8'h05));
    step(1'b1, 1'b0, 4'h0); chk("ldw_exec_fn", 32'(AluFn), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h0);
      chk("ldw_wait", 32'({MemReq, AddrSel, RegWe}), 32'b1010);
    end
    step(1'b1, 1'b1, 4'h0);
    chk("ldw_ack", 32'({MemReq, AddrSel, RegWe, WdSel}), 32'b10111);

    // PUSH_LINK then POP_LINK
    fetch(mk(PUSH_POP, {PUSH_LINK, 1'b0}, 8'h00));
    step(1'b1, 1'b0, 4'h0); chk("pushl_exec_sp", 32'(SpOp), 32'd2);
    step(1'b1, 1'b1, 4'h0);
    chk("pushl_mem", 32'({MemWrite, AddrSel, SpOp}), 32'b11000);
    fetch(mk(PUSH_POP, {POP_LINK, 1'b0}, 8'h00));
    step(1'b1, 1'b0, 4'h0); chk("popl_exec_sp", 32'(SpOp), 32'd0);
    step(1'b1, 1'b1, 4'h0);
    chk("popl_ack", 32'({LrWe, LrSel, SpOp, RegWe, MemWrite}), 32'b110100);

    // Illegal XOR
    fetch(mk(5'b10010, 3'd0, 8'h00));
    step(1'b1, 1'b0, 4'h0);
    chk("xor_ill", 32'({Illegal, MemReq, IrWe, PcWe, RegWe, LrWe, FlagsWe, SpOp}), 32'b1_000000_00);
    step(1'b1, 1'b0, 4'h0);
    chk("xor_resume", 32'({Illegal, MemReq}), 32'b01);

    // STW aborted by reset in MEM
    fetch(mk(STW, 3'd3, 8'h02));
    step(1'b1, 1'b0, 4'h0); chk("stw_exec_rs1", 32'(Rs1Sel), 32'd1);
    step(1'b1, 1'b0, 4'h0); chk("stw_mem", 32'({MemReq, MemWrite, AddrSel}), 32'b1101);
    step(1'b0, 1'b1, 4'h0); chk("stw_rst_abort", 32'(dut_o), 32'd0);
    step(1'b1, 1'b0, 4'h0);
    chk("stw_refetch", 32'({MemReq, MemWrite, AddrSel}), 32'b1000);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      next_instr = 16'($urandom);
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)));
    end

    @(posedge Clock);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
